// File: rtl/chip8_sequencer_if.sv
// Memory read bus and execution-unit handshake for chip8_sequencer.
// master: sequencer side (drives mem_addr/mem_rd/exec_start/exec_code).
interface chip8_sequencer_if;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_rvalid;
  logic        exec_start;
  logic [4:0]  exec_code;
  logic        exec_done;
  logic        skip_true;

  modport master (
    output mem_addr, mem_rd, exec_start, exec_code,
    input  mem_rdata, mem_rvalid, exec_done, skip_true
  );

  modport slave (
    input  mem_addr, mem_rd, exec_start, exec_code,
    output mem_rdata, mem_rvalid, exec_done, skip_true
  );
endinterface

// File: rtl/chip8_sequencer.sv
// CHIP-8 fetch/dispatch sequencer: byte-wise big-endian fetch, control
// flow (JMP/CALL/RET/skips), PC and call stack; other ops go to exec unit.
// Ports: clk, rst (sync, active-high), bus (chip8_sequencer_if.master:
// mem read bus + exec start/done), instruction, decode_in, addr_in,
// pc, fault. Optional macro CHIP8_STACK_CHECK_EN enables stack
// over/underflow detection and the FAULT state.
module chip8_sequencer #(
  parameter logic [11:0] PC_RESET    = 12'h200,
  parameter int          STACK_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  chip8_sequencer_if.master       bus,
  output logic [15:0]             instruction,
  input  logic [4:0]              decode_in,
  input  logic [11:0]             addr_in,
  output logic [11:0]             pc,
  output logic                    fault
);

  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
`ifdef CHIP8_STACK_CHECK_EN
  // One extra bit so a full stack (sp == STACK_DEPTH) is representable.
  localparam int SW = IW + 1;
`else
  // sp wraps modulo STACK_DEPTH naturally.
  localparam int SW = IW;
`endif

  localparam logic [4:0] OP_NONE     = 5'd0;
  localparam logic [4:0] OP_RET      = 5'd2;
  localparam logic [4:0] OP_JMP      = 5'd3;
  localparam logic [4:0] OP_CALL     = 5'd4;
  localparam logic [4:0] OP_SE_VAL   = 5'd5;
  localparam logic [4:0] OP_SNE_VAL  = 5'd6;
  localparam logic [4:0] OP_SE_VXVY  = 5'd7;
  localparam logic [4:0] OP_SNE_VXVY = 5'd19;

  typedef enum logic [2:0] {
    FETCH_HI,
    WAIT_HI,
    FETCH_LO,
    WAIT_LO,
    DEC,
    DISPATCH,
    EXEC_WAIT,
    FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [11:0]   pc_q, pc_d;
  logic [SW-1:0] sp_q, sp_d;
  logic [15:0]   instr_q, instr_d;
  logic [4:0]    exec_code_q, exec_code_d;
  logic [11:0]   stack_q [STACK_DEPTH];

  logic          push_en;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] pop_idx;
  logic          call_ok;
  logic          ret_ok;
  logic          is_ctrl;
  logic          is_skip;

  assign push_idx = sp_q[IW-1:0];
  assign pop_idx  = sp_q[IW-1:0] - IW'(1);

`ifdef CHIP8_STACK_CHECK_EN
  assign call_ok = (sp_q != SW'(STACK_DEPTH));
  assign ret_ok  = (sp_q != '0);
`else
  assign call_ok = 1'b1;
  assign ret_ok  = 1'b1;
`endif

  assign is_ctrl = decode_in inside {OP_NONE, OP_RET, OP_JMP, OP_CALL};
  assign is_skip = exec_code_q inside
    {OP_SE_VAL, OP_SNE_VAL, OP_SE_VXVY, OP_SNE_VXVY};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH_HI;
      pc_q        <= PC_RESET;
      sp_q        <= '0;
      instr_q     <= '0;
      exec_code_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      instr_q     <= instr_d;
      exec_code_q <= exec_code_d;
    end
  end

  // Stack contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_en && !rst) begin
      stack_q[push_idx] <= pc_q + 12'd2;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    sp_d        = sp_q;
    instr_d     = instr_q;
    exec_code_d = exec_code_q;
    push_en     = 1'b0;
    unique case (state_q)
      FETCH_HI: state_d = WAIT_HI;
      WAIT_HI: begin
        if (bus.mem_rvalid) begin
          instr_d[15:8] = bus.mem_rdata;
          state_d       = FETCH_LO;
        end
      end
      FETCH_LO: state_d = WAIT_LO;
      WAIT_LO: begin
        if (bus.mem_rvalid) begin
          instr_d[7:0] = bus.mem_rdata;
          state_d      = DEC;
        end
      end
      DEC: state_d = DISPATCH;
      DISPATCH: begin
        state_d = FETCH_HI;
        case (decode_in)
          OP_JMP: pc_d = addr_in;
          OP_CALL: begin
            if (call_ok) begin
              push_en = 1'b1;
              sp_d    = sp_q + SW'(1);
              pc_d    = addr_in;
            end else begin
              state_d = FAULT;
            end
          end
          OP_RET: begin
            if (ret_ok) begin
              sp_d = sp_q - SW'(1);
              pc_d = stack_q[pop_idx];
            end else begin
              state_d = FAULT;
            end
          end
          OP_NONE: pc_d = pc_q + 12'd2;
          default: begin
            exec_code_d = decode_in;
            state_d     = EXEC_WAIT;
          end
        endcase
      end
      EXEC_WAIT: begin
        if (bus.exec_done) begin
          state_d = FETCH_HI;
          if (is_skip && bus.skip_true) begin
            pc_d = pc_q + 12'd4;
          end else begin
            pc_d = pc_q + 12'd2;
          end
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = FETCH_HI;
    endcase
  end

  // Output logic; strobes are held low while rst is asserted.
  always_comb begin
    bus.mem_rd     = 1'b0;
    bus.mem_addr   = '0;
    bus.exec_start = 1'b0;
    if (!rst) begin
      unique case (state_q)
        FETCH_HI: begin
          bus.mem_rd   = 1'b1;
          bus.mem_addr = pc_q;
        end
        FETCH_LO: begin
          bus.mem_rd   = 1'b1;
          bus.mem_addr = pc_q + 12'd1;
        end
        DISPATCH: bus.exec_start = !is_ctrl;
        default: ;
      endcase
    end
`ifdef CHIP8_STACK_CHECK_EN
    fault = (state_q == FAULT);
`else
    fault = 1'b0;
`endif
  end

  assign bus.exec_code = exec_code_q;
  assign instruction   = instr_q;
  assign pc            = pc_q;

endmodule

// File: tb/tb_chip8_sequencer.sv
// Directed self-checking bench for chip8_sequencer with memory,
// registered decoder and execution-unit models.
module tb_chip8_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instruction;
  logic [4:0]  decode_in;
  logic [11:0] addr_in;
  logic [11:0] pc;
  logic        fault;

  chip8_sequencer_if bus();

  chip8_sequencer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .instruction(instruction),
    .decode_in(decode_in),
    .addr_in(addr_in),
    .pc(pc),
    .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [4096];
  int          mem_lat = 1;
  int          pend = 0;
  logic [11:0] pend_addr = '0;
  logic        skip_val = 1'b0;

  logic [11:0] rd_log [$];
  int          starts = 0;
  int          rd_base = 0;
  int          st_base = 0;

  always @(posedge clk) begin
    if (rst) begin
      pend <= 0;
      bus.mem_rvalid <= 1'b0;
    end else if (bus.mem_rd) begin
      if (mem_lat <= 1) begin
        bus.mem_rvalid <= 1'b1;
        bus.mem_rdata  <= mem[bus.mem_addr];
        pend <= 0;
      end else begin
        bus.mem_rvalid <= 1'b0;
        pend <= mem_lat - 1;
        pend_addr <= bus.mem_addr;
      end
    end else if (pend != 0) begin
      pend <= pend - 1;
      bus.mem_rvalid <= (pend == 1);
      if (pend == 1) bus.mem_rdata <= mem[pend_addr];
    end else begin
      bus.mem_rvalid <= 1'b0;
    end
  end

  always @(posedge clk) bus.exec_done <= !rst && bus.exec_start;
  assign bus.skip_true = skip_val;

  function automatic logic [4:0] dec(input logic [15:0] i);
    case (i[15:12])
      4'h0: dec = (i == 16'h00E0) ? 5'd1 :
                  (i == 16'h00EE) ? 5'd2 : 5'd0;
      4'h1: dec = 5'd3;
      4'h2: dec = 5'd4;
      4'h3: dec = 5'd5;
      4'h4: dec = 5'd6;
      4'h5: dec = (i[3:0] == 4'h0) ? 5'd7 : 5'd0;
      4'h6: dec = 5'd8;
      4'h9: dec = (i[3:0] == 4'h0) ? 5'd19 : 5'd0;
      default: dec = 5'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    decode_in <= dec(instruction);
    addr_in   <= instruction[11:0];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_rd) rd_log.push_back(bus.mem_addr);
      if (bus.exec_start) starts++;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  endtask

  task automatic put16(input logic [11:0] a, input logic [15:0] v);
    mem[a] = v[15:8];
    mem[a + 12'd1] = v[7:0];
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_base = rd_log.size();
    st_base = starts;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    clear_mem();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pc !== 12'h200) begin
      failures++; $display("FAIL rst_pc got=%h exp=200", pc);
    end
    checks++;
    if ({bus.mem_rd, bus.exec_start, fault} !== 3'b000) begin
      failures++;
      $display("FAIL rst_strobes got=%b exp=000",
               {bus.mem_rd, bus.exec_start, fault});
    end
    checks++;
    if (bus.mem_addr !== 12'h000) begin
      failures++; $display("FAIL rst_addr got=%h exp=000", bus.mem_addr);
    end
    checks++;
    if ({instruction, bus.exec_code} !== 21'd0) begin
      failures++;
      $display("FAIL rst_instr got=%h/%h exp=0/0",
               instruction, bus.exec_code);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    rd_base = rd_log.size();
    @(negedge clk);
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 12'h200) begin
      failures++;
      $display("FAIL first_rd got=%b@%h exp=1@200",
               bus.mem_rd, bus.mem_addr);
    end
  endtask

  task automatic test_exec();
    int n;
    clear_mem();
    put16(12'h200, 16'h00E0);
    put16(12'h202, 16'h1202);
    do_reset();
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.exec_start === 1'b1) begin
        n = c;
        break;
      end
    end
    checks++;
    if (n != 6) begin
      failures++; $display("FAIL exec_start_cycle got=%0d exp=6", n);
    end
    @(negedge clk);
    checks++;
    if (bus.exec_code !== 5'd1 || pc !== 12'h200) begin
      failures++;
      $display("FAIL exec_wait got=%0d/%h exp=1/200", bus.exec_code, pc);
    end
    @(negedge clk);
    checks++;
    if (pc !== 12'h202) begin
      failures++; $display("FAIL exec_pc got=%h exp=202", pc);
    end
    checks++;
    if (rd_log[rd_base] !== 12'h200 || rd_log[rd_base+1] !== 12'h201) begin
      failures++;
      $display("FAIL exec_reads got=%h,%h exp=200,201",
               rd_log[rd_base], rd_log[rd_base+1]);
    end
  endtask

  task automatic test_jump();
    clear_mem();
    put16(12'h200, 16'h1ABC);
    put16(12'hABC, 16'h1ABC);
    do_reset();
    run(6);
    checks++;
    if (pc !== 12'h200) begin
      failures++; $display("FAIL jmp_pc_hold got=%h exp=200", pc);
    end
    run(1);
    checks++;
    if (pc !== 12'hABC) begin
      failures++; $display("FAIL jmp_pc got=%h exp=abc", pc);
    end
    run(10);
    checks++;
    if (rd_log[rd_base+2] !== 12'hABC || rd_log[rd_base+3] !== 12'hABD) begin
      failures++;
      $display("FAIL jmp_reads got=%h,%h exp=abc,abd",
               rd_log[rd_base+2], rd_log[rd_base+3]);
    end
    checks++;
    if (starts != st_base) begin
      failures++;
      $display("FAIL jmp_no_exec got=%0d exp=0", starts - st_base);
    end
  endtask

  task automatic test_call_ret();
    clear_mem();
    put16(12'h200, 16'h2300);
    put16(12'h300, 16'h00EE);
    put16(12'h202, 16'h1202);
    do_reset();
    run(7);
    checks++;
    if (pc !== 12'h300) begin
      failures++; $display("FAIL call_pc got=%h exp=300", pc);
    end
    run(6);
    checks++;
    if (pc !== 12'h202) begin
      failures++; $display("FAIL ret_pc got=%h exp=202", pc);
    end
    run(20);
    checks++;
    if (rd_log[rd_base+4] !== 12'h202 || pc !== 12'h202) begin
      failures++;
      $display("FAIL ret_fetch got=%h pc=%h exp=202",
               rd_log[rd_base+4], pc);
    end
  endtask

  task automatic test_skip();
    logic [15:0] ops [7];
    logic        sk  [7];
    logic [11:0] exp [7];
    ops = '{16'h3142, 16'h3142, 16'h4142, 16'h5120,
            16'h9120, 16'h9120, 16'h6142};
    sk  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    exp = '{12'h208, 12'h206, 12'h208, 12'h208,
            12'h206, 12'h208, 12'h206};
    clear_mem();
    put16(12'h200, 16'h1204);
    put16(12'h206, 16'h1206);
    put16(12'h208, 16'h1208);
    for (int k = 0; k < 7; k++) begin
      put16(12'h204, ops[k]);
      skip_val = sk[k];
      do_reset();
      run(40);
      checks++;
      if (pc !== exp[k] || starts - st_base != 1) begin
        failures++;
        $display("FAIL skip_%h_%b got=%h starts=%0d exp=%h starts=1",
                 ops[k], sk[k], pc, starts - st_base, exp[k]);
      end
    end
    skip_val = 1'b0;
  endtask

  task automatic test_wrap();
    clear_mem();
    put16(12'h200, 16'h1FFF);
    mem[12'hFFF] = 8'h10;
    mem[12'h000] = 8'h10;
    mem[12'h001] = 8'h10;
    put16(12'h010, 16'h1010);
    do_reset();
    run(20);
    checks++;
    if (rd_log[rd_base+2] !== 12'hFFF || rd_log[rd_base+3] !== 12'h000) begin
      failures++;
      $display("FAIL wrap_reads got=%h,%h exp=fff,000",
               rd_log[rd_base+2], rd_log[rd_base+3]);
    end
    put16(12'h200, 16'h1FFE);
    mem[12'hFFE] = 8'h00;
    do_reset();
    run(13);
    checks++;
    if (pc !== 12'h000) begin
      failures++; $display("FAIL wrap_pc got=%h exp=000", pc);
    end
  endtask

  task automatic test_stack();
    int sz;
    clear_mem();
    for (int k = 0; k < 16; k++) begin
      put16(12'h200 + 12'(16 * k), 16'h2000 | 16'(12'h200 + 12'(16 * (k + 1))));
    end
    put16(12'h2F2, 16'h12F2);
    put16(12'h300, 16'h2400);
    put16(12'h302, 16'h1302);
    put16(12'h400, 16'h00EE);
    do_reset();
    run(100);
    checks++;
    if (pc !== 12'h300) begin
      failures++; $display("FAIL stack_fill_pc got=%h exp=300", pc);
    end
    run(20);
`ifdef CHIP8_STACK_CHECK_EN
    checks++;
    if (pc !== 12'h300 || fault !== 1'b1) begin
      failures++;
      $display("FAIL overflow got=%h/%b exp=300/1", pc, fault);
    end
    sz = rd_log.size();
    run(10);
    checks++;
    if (rd_log.size() != sz) begin
      failures++;
      $display("FAIL overflow_rd got=%0d exp=0", rd_log.size() - sz);
    end
`else
    checks++;
    if (pc !== 12'h302 || fault !== 1'b0) begin
      failures++;
      $display("FAIL overflow_wrap got=%h/%b exp=302/0", pc, fault);
    end
`endif
    put16(12'h200, 16'h00EE);
    do_reset();
    run(7);
`ifdef CHIP8_STACK_CHECK_EN
    checks++;
    if (pc !== 12'h200 || fault !== 1'b1) begin
      failures++;
      $display("FAIL underflow got=%h/%b exp=200/1", pc, fault);
    end
    run(10);
    checks++;
    if (rd_log.size() - rd_base != 2) begin
      failures++;
      $display("FAIL underflow_rd got=%0d exp=2", rd_log.size() - rd_base);
    end
`else
    checks++;
    if (pc !== 12'h2F2 || fault !== 1'b0) begin
      failures++;
      $display("FAIL underflow_wrap got=%h/%b exp=2f2/0", pc, fault);
    end
`endif
    do_reset();
    run(1);
    checks++;
    if (pc !== 12'h200 || fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_clear got=%h/%b exp=200/0", pc, fault);
    end
  endtask

  task automatic test_reset_midop();
    clear_mem();
    put16(12'h200, 16'h1ABC);
    mem_lat = 3;
    do_reset();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (instruction !== 16'h1A00) begin
      failures++; $display("FAIL mid_hi got=%h exp=1a00", instruction);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (instruction !== 16'h0000 || pc !== 12'h200) begin
      failures++;
      $display("FAIL mid_rst got=%h/%h exp=0000/200", instruction, pc);
    end
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 12'h200) begin
      failures++;
      $display("FAIL mid_refetch got=%b@%h exp=1@200",
               bus.mem_rd, bus.mem_addr);
    end
    mem_lat = 1;
  endtask

  initial begin
    test_reset();
    test_exec();
    test_jump();
    test_call_ret();
    test_skip();
    test_wrap();
    test_stack();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chip8_sequencer.md
# chip8_sequencer

Fetch/dispatch controller for the CHIP-8 core. It reads each 16-bit instruction as two bytes from byte-wide program memory, big-endian, and presents the instruction to the registered decoder. It executes control-flow opcodes itself: jump, call, return, and the PC side of skips. All other opcodes go to the execution unit through a start/done handshake. The block owns the program counter and the call stack.

## Interface
- `PC_RESET`, 12'h200: PC value after reset.
- `STACK_DEPTH`, 16: call-stack entries. Must be a power of two, at most 16.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `mem_addr`  out  12  byte address of the current read.
- `mem_rd`  out  1  one-cycle read strobe.
- `mem_rdata`  in  8  read data; valid while `mem_rvalid` is high.
- `mem_rvalid`  in  1  read-data valid, one cycle, at least 1 cycle after `mem_rd`.
- `instruction`  out  16  assembled opcode. Drives the decoder input.
- `decode_in`  in  5  decoder operation code (1=DISP_CLR, 2=RET, 3=JMP, 4=CALL, 5=SE_VAL, 6=SNE_VAL, 7=SE_VX_VY, 19=SNE_VX_VY, 0=unknown).
- `addr_in`  in  12  decoder address field (low 12 bits of the decoder's `addr_out`).
- `exec_start`  out  1  one-cycle dispatch pulse to the execution unit.
- `exec_code`  out  5  operation code held for the duration of execution.
- `exec_done`  in  1  execution complete; sampled only in EXEC_WAIT.
- `skip_true`  in  1  skip-condition result; valid in the same cycle as `exec_done`.
- `pc`  out  12  current program counter.
- `fault`  out  1  sticky stack-error flag.

## Operation
- States: FETCH_HI, WAIT_HI, FETCH_LO, WAIT_LO, DEC, DISPATCH, EXEC_WAIT, FAULT.
- FETCH_HI
  - `mem_addr`=pc, `mem_rd`=1 for one cycle.
  - Then WAIT_HI.
- WAIT_HI
  - Holds until `mem_rvalid`.
  - On `mem_rvalid`, captures `instruction[15:8]` and goes to FETCH_LO.
- FETCH_LO
  - `mem_addr`=pc+1 (mod 4096), `mem_rd`=1.
  - Then WAIT_LO.
- WAIT_LO
  - On `mem_rvalid`, captures `instruction[7:0]` and goes to DEC.
- DEC
  - One-cycle wait while the decoder registers its output.
  - Then DISPATCH.
- DISPATCH samples `decode_in` and `addr_in`:
  - JMP (3): pc←addr_in, then FETCH_HI.
  - CALL (4): push pc+2 to stack[sp], sp←sp+1, pc←addr_in, then FETCH_HI.
  - RET (2): sp←sp−1, pc←stack[sp−1], then FETCH_HI.
  - 0 (unknown): pc←pc+2 (treated as NOP), then FETCH_HI.
  - Any other code: `exec_start`=1, `exec_code`←decode_in, then EXEC_WAIT.
- EXEC_WAIT
  - On `exec_done`: for codes 5, 6, 7, 19, pc←pc+4 if `skip_true`, else pc←pc+2. For all other codes, pc←pc+2.
  - Then FETCH_HI.
- PC arithmetic is 12-bit and wraps modulo 4096: 12'hFFE+2 = 12'h000. Odd PC values are legal.
- `mem_rvalid` outside WAIT_HI/WAIT_LO is ignored. `exec_done` outside EXEC_WAIT is ignored.
- FAULT
  - Terminal state; only `rst` exits it.
  - `mem_rd`=0, `exec_start`=0, pc frozen, `fault`=1.

## Timing
- Reset values: state FETCH_HI, pc=PC_RESET, sp=0, `mem_addr`=0, `mem_rd`=0, `instruction`=0, `exec_start`=0, `exec_code`=0, `fault`=0. Stack contents are not reset.
- `rst` mid-operation has the same effect from any state, including FAULT. Memory and execution unit share `rst`, so no stale responses arrive after reset.
- `mem_rd` first rises in the cycle after reset deasserts.
- Minimum instruction period with 1-cycle memory latency:
  - control-flow opcode: 6 cycles (FETCH_HI, WAIT_HI, FETCH_LO, WAIT_LO, DEC, DISPATCH).
  - executed opcode: 7 cycles + execution latency.
- `instruction` stays stable from the WAIT_LO capture until the next WAIT_HI capture.
- `exec_code` stays stable from DISPATCH until the next DISPATCH.
- `pc` updates on the clock edge that leaves DISPATCH or EXEC_WAIT.
- `exec_done` in the same cycle as `exec_start` is ignored. `exec_done` is honoured from the cycle after `exec_start` onward.

## Configuration
- `CHIP8_STACK_CHECK_EN` defined:
  - CALL with sp==STACK_DEPTH, or RET with sp==0, goes to FAULT without modifying pc, sp or the stack.
  - `fault` is asserted from the next cycle.
- Not defined:
  - sp wraps modulo STACK_DEPTH. Overflow overwrites the oldest entry; underflow reads stack[STACK_DEPTH−1].
  - `fault` is tied to 0 and FAULT is unreachable.

## Test plan
- Reset with program 00E0 at 0x200 → reads at 0x200 then 0x201; `exec_start` with `exec_code`=1; after `exec_done`, pc=0x202.
- 1ABC at 0x200 → pc=0xABC; no `exec_start`; next `mem_rd` at 0xABC.
- 2300 at 0x200, then 00EE at 0x300 → after CALL pc=0x300, sp=1; after RET pc=0x202, sp=0.
- 3x42 with `skip_true`=1 at pc=0x204 → pc=0x208. Same with `skip_true`=0 → pc=0x206.
- 00EE at reset with `CHIP8_STACK_CHECK_EN` → `fault`=1, no further `mem_rd`. Then `rst` → pc=0x200, `fault`=0. Without the macro: pc=stack[15], no fault.
- Assert `rst` during WAIT_LO with 3-cycle memory latency → FETCH_HI, pc=0x200, `instruction`=0. Also jump to 0xFFF → read 0xFFF then 0x000.
